// File: rtl/apb_clint_timer.sv
// -----------------------------------------------------------------------------
// apb_clint_timer
//
// APB responder holding the machine timer and software-interrupt registers
// (msip, mtimecmp, mtime). It sits on the core's APB bus in its own address
// window. It owns the free-running 64-bit mtime count and drives the level
// interrupts the core consumes.
//
// Register map (byte offsets, paddr[15:0]):
//   0x0000  msip          bit 0 only; other bits read as zero, writes ignored
//   0x4000  mtimecmp[31:0]
//   0x4004  mtimecmp[63:32]
//   0xBFF8  mtime[31:0]
//   0xBFFC  mtime[63:32]
// Any other offset, or an offset that is not word aligned, completes with
// pslverr=1. An erroring write changes nothing and an erroring read returns 0.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous reset, active-high
//   psel        APB select
//   penable     APB enable (ACCESS phase)
//   pready      APB ready; high on the completing ACCESS cycle only
//   paddr       APB byte address (only bits [15:0] are decoded)
//   pwrite      1 = write, 0 = read
//   pwdata      write data
//   pwstrb      byte write strobes
//   prdata      read data; valid on the completing cycle, otherwise 0
//   pslverr     error response; valid on the completing cycle, otherwise 0
//   mtime       current mtime value
//   mtimer_int  timer interrupt, level: mtime >= mtimecmp (unsigned)
//   msoft_int   software interrupt, level: msip[0]
//
// Parameters:
//   ADDR_W       APB address width seen by this block (>= 16)
//   TICK_DIV     clk cycles per mtime increment (>= 1)
//   WAIT_STATES  extra ACCESS cycles inserted before pready (0..15)
// -----------------------------------------------------------------------------
module apb_clint_timer #(
   parameter int ADDR_W      = 16,
   parameter int TICK_DIV    = 1,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   output logic              pready,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic [31:0]       pwdata,
   input  logic [3:0]        pwstrb,
   output logic [31:0]       prdata,
   output logic              pslverr,
   output logic [63:0]       mtime,
   output logic              mtimer_int,
   output logic              msoft_int
);

   // A one-bit prescaler is kept even for TICK_DIV=1 so the vector is never
   // zero-width; it simply stays at 0 and every cycle is a tick.
   localparam int             PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [3:0]     WS      = 4'(WAIT_STATES);

   localparam logic [15:0] OFF_MSIP   = 16'h0000;
   localparam logic [15:0] OFF_CMP_LO = 16'h4000;
   localparam logic [15:0] OFF_CMP_HI = 16'h4004;
   localparam logic [15:0] OFF_MT_LO  = 16'hBFF8;
   localparam logic [15:0] OFF_MT_HI  = 16'hBFFC;

   // Replace only the strobed bytes of a 32-bit word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   // State
   logic [3:0]       wcnt_q,     wcnt_d;
   logic [PRE_W-1:0] presc_q,    presc_d;
   logic [63:0]      mtime_q,    mtime_d;
   logic [63:0]      mtimecmp_q, mtimecmp_d;
   logic             msip_q,     msip_d;

   // Address decode
   logic [15:0] off;
   logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
   logic        mapped, addr_err;

   assign off        = paddr[15:0];
   assign sel_msip   = (off == OFF_MSIP);
   assign sel_cmp_lo = (off == OFF_CMP_LO);
   assign sel_cmp_hi = (off == OFF_CMP_HI);
   assign sel_mt_lo  = (off == OFF_MT_LO);
   assign sel_mt_hi  = (off == OFF_MT_HI);
   assign mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
   assign addr_err   = ~mapped | (off[1:0] != 2'b00);

   // Transfer handshake. pready is forced low while reset is held so an
   // in-flight transfer is aborted rather than completed.
   logic access, done, wr_ok, rd_ok, tick;

   assign access = psel & penable;
   assign pready = access & (wcnt_q == WS) & ~rst;
   assign done   = pready;
   assign wr_ok  = done & pwrite  & ~addr_err;
   assign rd_ok  = done & ~pwrite & ~addr_err;
   assign tick   = (presc_q == PRE_MAX);

   // Wait-state counter: runs only while an ACCESS cycle is stalled, and
   // returns to zero when the slave is deselected or the transfer completes.
   always_comb begin
      wcnt_d = wcnt_q;
      if (!psel || done) begin
         wcnt_d = 4'd0;
      end else if (access) begin
         wcnt_d = wcnt_q + 4'd1;
      end
   end

   // Prescaler always advances, even on a cycle where mtime is written.
   always_comb begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
   end

   // mtime: a write to either half wins over the tick; the other half and
   // the unstrobed bytes hold, so no carry or increment happens that cycle.
   always_comb begin
      mtime_d = mtime_q;
      if (wr_ok && sel_mt_lo) begin
         mtime_d[31:0] = merge_bytes(mtime_q[31:0], pwdata, pwstrb);
      end else if (wr_ok && sel_mt_hi) begin
         mtime_d[63:32] = merge_bytes(mtime_q[63:32], pwdata, pwstrb);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      if (wr_ok && sel_cmp_lo) begin
         mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], pwdata, pwstrb);
      end else if (wr_ok && sel_cmp_hi) begin
         mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], pwdata, pwstrb);
      end
   end

   always_comb begin
      msip_d = msip_q;
      if (wr_ok && sel_msip && pwstrb[0]) begin
         msip_d = pwdata[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q     <= 4'd0;
         presc_q    <= '0;
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q     <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
      end
   end

   // Read mux; prdata is only non-zero on a successful read completion.
   logic [31:0] rdata;

   always_comb begin
      rdata = 32'd0;
      if (sel_msip)   rdata = {31'd0, msip_q};
      if (sel_cmp_lo) rdata = mtimecmp_q[31:0];
      if (sel_cmp_hi) rdata = mtimecmp_q[63:32];
      if (sel_mt_lo)  rdata = mtime_q[31:0];
      if (sel_mt_hi)  rdata = mtime_q[63:32];
   end

   assign prdata     = rd_ok ? rdata : 32'd0;
   assign pslverr    = done & addr_err;
   assign mtime      = mtime_q;
   assign mtimer_int = (mtime_q >= mtimecmp_q);
   assign msoft_int  = msip_q;

endmodule

// File: tb/tb_apb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_apb_clint_timer
//
// Two instances: A (TICK_DIV=1, WAIT_STATES=0) and B (TICK_DIV=4,
// WAIT_STATES=3) share every bus input except psel. The reference model
// describes mtime arithmetically: after n clock edges since reset, with the
// last software write to mtime leaving value V at edge e, mtime equals
// V + floor(n/DIV) - floor(e/DIV).
// -----------------------------------------------------------------------------
module tb_apb_clint_timer;

   localparam int DIV_A = 1;
   localparam int DIV_B = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel_a, psel_b, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pwstrb;

   logic        pready_a, pslverr_a, mtimer_int_a, msoft_int_a;
   logic [31:0] prdata_a;
   logic [63:0] mtime_a;
   logic        pready_b, pslverr_b, mtimer_int_b, msoft_int_b;
   logic [31:0] prdata_b;
   logic [63:0] mtime_b;

   always #5 clk = ~clk;

   apb_clint_timer #(.ADDR_W(16), .TICK_DIV(DIV_A), .WAIT_STATES(0)) dut_a (
      .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pready(pready_a),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
      .prdata(prdata_a), .pslverr(pslverr_a), .mtime(mtime_a),
      .mtimer_int(mtimer_int_a), .msoft_int(msoft_int_a));

   apb_clint_timer #(.ADDR_W(16), .TICK_DIV(DIV_B), .WAIT_STATES(3)) dut_b (
      .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pready(pready_b),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
      .prdata(prdata_b), .pslverr(pslverr_b), .mtime(mtime_b),
      .mtimer_int(mtimer_int_b), .msoft_int(msoft_int_b));

   // ---------------- reference model ----------------
   longint unsigned n;             // clock edges since reset released
   logic [63:0]     mt_base [2];
   longint unsigned mt_edge [2];
   logic [63:0]     cmp_m   [2];
   logic            msip_m  [2];
   int              checks, errors;
   bit              chk_en;

   always @(posedge clk or posedge rst) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   function automatic logic [63:0] mexp(input int w, input longint unsigned nn);
      longint unsigned d;
      d = (w == 0) ? DIV_A : DIV_B;
      return mt_base[w] + 64'(nn / d) - 64'(mt_edge[w] / d);
   endfunction

   function automatic bit mapped(input logic [15:0] a);
      return (a == 16'h0000) || (a == 16'h4000) || (a == 16'h4004) ||
             (a == 16'hBFF8) || (a == 16'hBFFC);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input int w, input logic [15:0] a,
                                              input longint unsigned nn);
      logic [63:0] t;
      t = mexp(w, nn);
      case (a)
         16'h0000: return {31'd0, msip_m[w]};
         16'h4000: return cmp_m[w][31:0];
         16'h4004: return cmp_m[w][63:32];
         16'hBFF8: return t[31:0];
         16'hBFFC: return t[63:32];
         default:  return 32'd0;
      endcase
   endfunction

   // Called right after the committing edge, so n is that edge's index.
   task automatic model_write(input int w, input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] s);
      logic [63:0] pre;
      pre = mexp(w, n - 1);
      case (a)
         16'h0000: if (s[0]) msip_m[w] = d[0];
         16'h4000: cmp_m[w][31:0]  = merge(cmp_m[w][31:0], d, s);
         16'h4004: cmp_m[w][63:32] = merge(cmp_m[w][63:32], d, s);
         16'hBFF8: begin mt_base[w] = {pre[63:32], merge(pre[31:0], d, s)}; mt_edge[w] = n; end
         16'hBFFC: begin mt_base[w] = {merge(pre[63:32], d, s), pre[31:0]}; mt_edge[w] = n; end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mt_base[i] = 64'd0; mt_edge[i] = 0;
         cmp_m[i] = 64'hFFFF_FFFF_FFFF_FFFF; msip_m[i] = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle: timer state and idle outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mtime_a", mtime_a, mexp(0, n));
         chk("mtime_b", mtime_b, mexp(1, n));
         chk("mtip_a", mtimer_int_a, mexp(0, n) >= cmp_m[0]);
         chk("mtip_b", mtimer_int_b, mexp(1, n) >= cmp_m[1]);
         chk("msip_a", msoft_int_a, msip_m[0]);
         chk("msip_b", msoft_int_b, msip_m[1]);
         if (!psel_a) chk("idle_a", {pready_a, pslverr_a, prdata_a}, 64'd0);
         if (!psel_b) chk("idle_b", {pready_b, pslverr_b, prdata_b}, 64'd0);
      end
   end

   // ---------------- bus driver ----------------
   task automatic apb(input int w, input logic [15:0] a, input bit wr, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int ws);
      bit got;
      bit eer;
      got = 0; eer = 1; rd = 0; er = 0; ws = 0;
      @(posedge clk); #1;
      paddr = a; pwrite = wr; pwdata = d; pwstrb = s; penable = 1'b0;
      if (w == 0) psel_a = 1'b1; else psel_b = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if ((w == 0) ? pready_a : pready_b) begin
            got = 1;
            rd  = (w == 0) ? prdata_a : prdata_b;
            er  = (w == 0) ? pslverr_a : pslverr_b;
            eer = !mapped(a);
            chk("apb_err", er, eer);
            if (!wr) chk("apb_rdata", rd, (eer ? 32'd0 : model_read(w, a, n)));
         end else begin
            ws++;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL apb_timeout: dut %0d addr 0x%h got no pready expected pready within 20 cycles", w, a);
      end
      @(posedge clk); #1;
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0; pwstrb = 4'h0;
      if (got && wr && !eer) model_write(w, a, d, s);
   endtask

   task automatic wait_n(input longint unsigned k);
      int g;
      g = 0;
      @(negedge clk);
      while (n < k && g < 1000) begin @(negedge clk); g++; end
   endtask

   typedef struct {
      logic [15:0] addr;
      bit          wr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          exp_err;
      logic [31:0] exp_rd;
      bit          exp_msoft;
   } vec_t;

   vec_t        tbl [14];
   logic [31:0] rd;
   logic        er;
   int          ws, g, rw, rsel;
   logic [15:0] ra;
   logic [15:0] base_addrs [5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0; chk_en = 0;
      psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
      paddr = 0; pwdata = 0; pwstrb = 0;
      model_reset();
      base_addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};

      // cmp_a = 0x00000001_00000020 and msip=0 when the table starts.
      tbl[0]  = '{16'h1234, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        1'b0};
      tbl[1]  = '{16'h4002, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,       1'b0};
      tbl[2]  = '{16'h4000, 1'b0, 32'h0,        4'h0, 1'b0, 32'h20,       1'b0};
      tbl[3]  = '{16'h4004, 1'b0, 32'h0,        4'h0, 1'b0, 32'h1,        1'b0};
      tbl[4]  = '{16'h0000, 1'b1, 32'h3,        4'hF, 1'b0, 32'h0,        1'b1};
      tbl[5]  = '{16'h0000, 1'b0, 32'h0,        4'hF, 1'b0, 32'h1,        1'b1};
      tbl[6]  = '{16'h0000, 1'b1, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1};
      tbl[7]  = '{16'h0000, 1'b0, 32'h0,        4'h0, 1'b0, 32'h1,        1'b1};
      tbl[8]  = '{16'h4004, 1'b1, 32'hAABB_CC01, 4'h4, 1'b0, 32'h0,       1'b1};
      tbl[9]  = '{16'h4004, 1'b0, 32'h0,        4'h0, 1'b0, 32'h00BB_0001, 1'b1};
      tbl[10] = '{16'h4001, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
      tbl[11] = '{16'h0004, 1'b1, 32'h1,        4'hF, 1'b1, 32'h0,        1'b1};
      tbl[12] = '{16'h0000, 1'b1, 32'hFFFF_FFFE, 4'h1, 1'b0, 32'h0,       1'b0};
      tbl[13] = '{16'hBFFA, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0,        1'b0};

      // Reset state, with an ACCESS presented to A during reset.
      repeat (2) @(posedge clk);
      #1; psel_a = 1; penable = 1; paddr = 16'hBFF8; chk_en = 1;
      @(negedge clk);
      chk("rst_pready", pready_a, 0);
      chk("rst_prdata", prdata_a, 0);
      chk("rst_pslverr", pslverr_a, 0);
      chk("rst_mtime", mtime_a, 0);
      chk("rst_mtip", mtimer_int_a, 0);
      chk("rst_msip", msoft_int_a, 0);
      @(posedge clk); #1;
      psel_a = 0; penable = 0; rst = 0;

      // 10 cycles at TICK_DIV=1, then prescaler wrap at TICK_DIV=4.
      wait_n(10);
      chk("t1_mtime_a", mtime_a, 64'd10);
      chk("t1_mtip_a", mtimer_int_a, 0);
      chk("t1_mtime_b", mtime_b, 64'd2);
      wait_n(39);
      chk("t2_mtime_b_39", mtime_b, 64'd9);
      @(negedge clk);
      chk("t2_mtime_b_40", mtime_b, 64'd10);
      apb(0, 16'h4004, 0, 0, 4'h0, rd, er, ws);
      chk("t1_cmp_hi", rd, 32'hFFFF_FFFF);
      chk("t1_err", er, 0);
      chk("t1_ws_a", ws, 0);

      // Timer compare: rises exactly when mtime reaches 0x20.
      apb(0, 16'hBFF8, 1, 32'h0, 4'hF, rd, er, ws);
      apb(0, 16'h4000, 1, 32'h20, 4'hF, rd, er, ws);
      apb(0, 16'h4004, 1, 32'h0, 4'hF, rd, er, ws);
      g = 0;
      while (mexp(0, n) != 64'h1F && g < 100) begin @(negedge clk); g++; end
      chk("t3_mtip_before", mtimer_int_a, 0);
      chk("t3_mtime_1f", mtime_a, 64'h1F);
      @(negedge clk);
      chk("t3_mtip_at", mtimer_int_a, 1);
      chk("t3_mtime_20", mtime_a, 64'h20);
      apb(0, 16'h4004, 1, 32'h1, 4'hF, rd, er, ws);
      @(negedge clk);
      chk("t3_mtip_clear", mtimer_int_a, 0);

      // Register access table.
      for (int i = 0; i < 14; i++) begin
         apb(0, tbl[i].addr, tbl[i].wr, tbl[i].data, tbl[i].strb, rd, er, ws);
         chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
         if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         @(negedge clk);
         chk($sformatf("tbl%0d_msoft", i), msoft_int_a, tbl[i].exp_msoft);
      end

      // Wait states on B.
      apb(1, 16'hBFF8, 0, 0, 4'h0, rd, er, ws);
      chk("t4_ws_b", ws, 3);
      apb(1, 16'h4000, 1, 32'h1234_5678, 4'hF, rd, er, ws);
      chk("t4_ws_b_wr", ws, 3);
      apb(1, 16'h1234, 0, 0, 4'h0, rd, er, ws);
      chk("t4_err_b", er, 1);

      // Strobed mtime write on a tick cycle, then 64-bit wrap.
      apb(0, 16'hBFFC, 1, 32'h0, 4'hF, rd, er, ws);
      apb(0, 16'hBFF8, 1, 32'hFFFF_FFFD, 4'hF, rd, er, ws);
      apb(0, 16'hBFF8, 1, 32'h0000_0055, 4'h1, rd, er, ws);
      @(negedge clk);
      chk("t6_strb", mtime_a, 64'h0000_0000_FFFF_FF55);
      apb(0, 16'hBFFC, 1, 32'hFFFF_FFFF, 4'hF, rd, er, ws);
      apb(0, 16'hBFF8, 1, 32'hFFFF_FFFD, 4'hF, rd, er, ws);
      g = 0;
      while (mexp(0, n) != 64'hFFFF_FFFF_FFFF_FFFF && g < 20) begin @(negedge clk); g++; end
      chk("t6_ones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("t6_wrap", mtime_a, 64'h0);

      // SETUP without ENABLE must not write msip.
      @(posedge clk); #1;
      psel_a = 1; penable = 0; pwrite = 1; paddr = 16'h0000; pwdata = 32'h1; pwstrb = 4'hF;
      repeat (3) begin @(negedge clk); chk("setup_pready", pready_a, 0); end
      @(posedge clk); #1;
      psel_a = 0; pwrite = 0; pwstrb = 0;

      // Random traffic on both instances against the model.
      for (int i = 0; i < 150; i++) begin
         rw   = $urandom_range(0, 1);
         rsel = $urandom_range(0, 6);
         if (rsel < 5)       ra = base_addrs[rsel];
         else if (rsel == 5) ra = 16'($urandom);
         else                ra = base_addrs[$urandom_range(0, 4)] | 16'($urandom_range(1, 3));
         apb(rw, ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, er, ws);
         chk("rand_ws", ws, (rw == 0) ? 0 : 3);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
